// File: rtl/demux16_reg.sv
// 1-to-16 registered write demultiplexer: one word per cycle lands in a channel
// register chosen explicitly or by an auto-incrementing pointer, with per-channel written flags.
module demux16_reg #(
  parameter int demux16_N = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_ena,
  input  logic [3:0]           wr_sel,
  input  logic [demux16_N-1:0] wr_data,
  input  logic                 auto_inc,
  input  logic                 clr,
  output logic [demux16_N-1:0] out00,
  output logic [demux16_N-1:0] out01,
  output logic [demux16_N-1:0] out02,
  output logic [demux16_N-1:0] out03,
  output logic [demux16_N-1:0] out04,
  output logic [demux16_N-1:0] out05,
  output logic [demux16_N-1:0] out06,
  output logic [demux16_N-1:0] out07,
  output logic [demux16_N-1:0] out08,
  output logic [demux16_N-1:0] out09,
  output logic [demux16_N-1:0] out10,
  output logic [demux16_N-1:0] out11,
  output logic [demux16_N-1:0] out12,
  output logic [demux16_N-1:0] out13,
  output logic [demux16_N-1:0] out14,
  output logic [demux16_N-1:0] out15,
  output logic [15:0]          written,
  output logic                 all_written,
  output logic [3:0]           next_sel
);

  logic [demux16_N-1:0] chan [16];
  logic [15:0]          written_q;
  logic [3:0]           ptr_q;
  logic [3:0]           target;
  logic [15:0]          target_onehot;

  assign target        = auto_inc ? ptr_q : wr_sel;
  assign target_onehot = 16'h0001 << target;

  // Both write modes leave the pointer just past the channel that was written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) chan[i] <= '0;
      written_q <= '0;
      ptr_q     <= '0;
    end else if (wr_ena) begin
      chan[target] <= wr_data;
      ptr_q        <= target + 4'd1;
      if (clr) written_q <= target_onehot;
      else     written_q <= written_q | target_onehot;
    end else if (clr) begin
      written_q <= '0;
    end
  end

  assign written     = written_q;
  assign all_written = (written_q == 16'hFFFF);
  assign next_sel    = ptr_q;

  assign out00 = chan[0];
  assign out01 = chan[1];
  assign out02 = chan[2];
  assign out03 = chan[3];
  assign out04 = chan[4];
  assign out05 = chan[5];
  assign out06 = chan[6];
  assign out07 = chan[7];
  assign out08 = chan[8];
  assign out09 = chan[9];
  assign out10 = chan[10];
  assign out11 = chan[11];
  assign out12 = chan[12];
  assign out13 = chan[13];
  assign out14 = chan[14];
  assign out15 = chan[15];

endmodule

// File: doc/demux16_reg.md
DEMUX16_REG -- requirements
Module: demux16_reg

Interface
REQ-001 SHALL have parameter demux16_N, default 5: width of each data word.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port wr_ena, input, 1: write request for the current cycle.
REQ-005 SHALL have port wr_sel, input, 4: explicit target channel, 0..15.
REQ-006 SHALL have port wr_data, input, demux16_N: word to write.
REQ-007 SHALL have port auto_inc, input, 1: when 1, target comes from the internal pointer and wr_sel is ignored.
REQ-008 SHALL have port clr, input, 1: clears the written flags.
REQ-009 SHALL have ports out00..out15, output, demux16_N each: the 16 channel holding registers.
REQ-010 SHALL have port written, output, 16: bit i set means channel i was written since the last rst or clr.
REQ-011 SHALL have port all_written, output, 1: high when written equals 16'hFFFF.
REQ-012 SHALL have port next_sel, output, 4: current internal pointer value.

Function
REQ-013 SHALL compute target as the pointer when auto_inc=1, otherwise as wr_sel.
REQ-014 SHALL, on a clock edge with wr_ena=1, load wr_data into out<target> and set written[target].
- Latency is 1 cycle: the new value is visible the cycle after the edge.
REQ-015 SHALL hold every non-target channel, and every channel when wr_ena=0.
REQ-016 SHALL, on an auto_inc write, advance the pointer to pointer+1 mod 16 (wrap 15 -> 0).
REQ-017 SHALL, on an explicit write (auto_inc=0), load the pointer with wr_sel+1 mod 16 (wr_sel=15 -> 0).
REQ-018 SHALL leave the pointer unchanged when wr_ena=0, regardless of auto_inc.
REQ-019 SHALL, when clr=1 with wr_ena=0, clear all written bits and leave channel data and pointer unchanged.
REQ-020 SHALL, when clr=1 and wr_ena=1 in the same cycle, perform the write and leave written equal to a one-hot of target.
REQ-021 SHALL drive all_written combinationally from the written register.
REQ-022 SHALL drive next_sel directly from the pointer register.
REQ-023 SHALL let a rewrite of an already-written channel overwrite its data, leave its flag set, and update the pointer as in REQ-016/REQ-017.
REQ-024 SHALL treat all inputs as don't-care for state when wr_ena=0 and clr=0.

Reset
REQ-025 SHALL, on a clock edge with rst=1, clear out00..out15 to 0, written to 0 and the pointer to 0.
- Afterwards next_sel=0 and all_written=0.
REQ-026 SHALL give rst priority over wr_ena and clr in the same cycle; no write takes effect.
REQ-027 SHALL, when rst asserts mid-sequence (pointer nonzero, some flags set), discard all state and resume from pointer 0 on the first edge after rst deasserts.

Verification
REQ-028 Reset: rst=1 for one edge after arbitrary writes -> all outNN=0, written=0, next_sel=0, all_written=0.
REQ-029 Explicit write: wr_ena=1, auto_inc=0, wr_sel=9, wr_data=5'h1A -> next cycle out09=5'h1A, written=16'h0200, next_sel=10, all other outs unchanged.
REQ-030 Auto-increment wrap: from reset, 16 auto_inc writes of data 0..15 -> outNN=NN for all NN, written=16'hFFFF, all_written=1, next_sel=0; a 17th write of 5'h1F lands in out00.
REQ-031 Mixed: explicit write wr_sel=15, then auto_inc write 5'h03 -> out15 holds the first word, out00=5'h03, next_sel=1.
REQ-032 Clear collision: with written=16'hFFFF, clr=1 and explicit write wr_sel=4 in the same cycle -> written=16'h0010, all_written=0, data in other channels retained.
REQ-033 Reset priority: rst=1, wr_ena=1, wr_sel=2, wr_data=5'h07 in the same cycle -> out02=0, written=0, next_sel=0.
